signal_divider: RTL

//   Multi-channel edge-driven signal divider and toggle generator.
//   - Each channel synchronises an asynchronous input into the clk domain and detects the selected edge type.
//   - Each channel counts qualifying edges and toggles its output every DIV of them. DIV=1 on falling edges
//     is the plain divide-by-2 toggle.
//   - Feeds derived slow clocks/enables and edge ticks to the lab display and counter logic.

---
 rtl/signal_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/signal_divider.sv
`default_nettype none
// ============================================================================
// Module      : signal_divider
// Description : Multi-channel edge-driven divider / toggle generator. Each
//               channel synchronises an asynchronous input, detects the
//               selected edge type and toggles its output every DIV
//               qualifying edges, pulsing tick in the toggle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_divider #(
  parameter int CH          = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] div,
  input  logic [CH-1:0]    in_sig,
  output logic [CH-1:0]    out_sig,
  output logic [CH-1:0]    tick
);

  // Edge-select encodings
  localparam logic [1:0] MODE_FALL = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  // Warm-up spans the chain fill plus the prev flop, so a level held across
  // reset can never look like a fresh edge.
  localparam int              WARM_N   = SYNC_STAGES + 1;
  localparam int              WARM_W   = $clog2(WARM_N + 1);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(WARM_N);

  logic [WARM_W-1:0] r_warm_cnt;
  logic              w_warm_done;
  logic [CNT_W-1:0]  w_divq;
  logic [CNT_W-1:0]  w_div_last;

  assign w_warm_done = (r_warm_cnt == WARM_END);

  // A divisor of zero is treated as one; the terminal count is divq-1.
  assign w_divq     = (div == '0) ? CNT_W'(1) : div;
  assign w_div_last = w_divq - CNT_W'(1);

  // Warm-up counter: counts clk edges after reset release, then saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warm_cnt <= '0;
    end else if (!w_warm_done) begin
      r_warm_cnt <= r_warm_cnt + WARM_W'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out;
    logic                   r_tick;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_q;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;
    assign w_fall = ~w_s & r_prev;

    // Synchroniser chain and prev sample run every cycle, independent of
    // en/clr, so re-enabling never fabricates an edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync <= '0;
        r_prev <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], in_sig[i]};
        r_prev <= w_s;
      end
    end

    // Edge qualification against the current mode, gated by en and warm-up.
    always_comb begin
      w_q = 1'b0;
      case (mode)
        MODE_FALL: w_q = w_fall;
        MODE_RISE: w_q = w_rise;
        MODE_BOTH: w_q = w_rise | w_fall;
        default:   w_q = 1'b0;
      endcase
      if (!en || !w_warm_done) begin
        w_q = 1'b0;
      end
    end

    // Edge counter and output toggle; >= compare makes a lowered divisor
    // terminate on the next edge instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (clr) begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_q) begin
        if (r_cnt >= w_div_last) begin
          r_cnt  <= '0;
          r_out  <= ~r_out;
          r_tick <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign out_sig[i] = r_out;
    assign tick[i]    = r_tick;
  end

endmodule
`default_nettype wire
